// File: rtl/ip_access_sequencer_pkg.sv
// Shared types and helpers for the IP access sequencer.
// Holds the FSM state encoding and packed-bus slicing.
package ip_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 8;

    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/ip_access_sequencer_if.sv
// Requester/response handshake bundle for the IP access sequencer.
// master = requester fabric side, slave = sequencer side.
interface ip_seq_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ*2-1:0]      req_sig;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic                      rsp_bit;

    modport master (
        output req_valid, req_data, req_sig, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_bit
    );

    modport slave (
        input  req_valid, req_data, req_sig, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_bit
    );

endinterface

// File: rtl/ip_access_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: first set request after last_grant.
// Grant is one-hot, index is its binary encoding; both zero when disabled.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    logic [ID_W-1:0] pos;
    logic            found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (enable && !found && req[pos]) begin
                grant[pos] = 1'b1;
                idx        = pos;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ip_access_sequencer.sv
// Shares one single-cycle IP datapath among NUM_REQ requesters,
// round-robin granting and returning each result tagged with its ID.
module ip_access_sequencer
    import ip_seq_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    ip_seq_if.slave           bus,
    output logic [DATA_W-1:0] ip_data_bus,
    output logic              ip_valid_signal,
    output logic              ip_signal1,
    output logic              ip_signal2,
    input  logic              ip_broken_output,
    output logic              busy
);

    state_t             state;
    logic [ID_W-1:0]    last_grant;
    logic [ID_W-1:0]    lat_id;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gidx;
    logic [DATA_W-1:0]  sel_data;
    logic [1:0]         sel_sig;

    // Gated by rst_n so req_ready is also zero while reset is held.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .enable     (rst_n && state == IDLE),
        .grant      (grant),
        .idx        (gidx)
    );

    assign bus.req_ready = grant;
    assign busy          = (state != IDLE);
    assign sel_data = bus.req_data[slice_lo(int'(gidx), DATA_W) +: DATA_W];
    assign sel_sig  = bus.req_sig[slice_lo(int'(gidx), 2) +: 2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            last_grant      <= ID_W'(NUM_REQ - 1);
            lat_id          <= '0;
            ip_data_bus     <= '0;
            ip_valid_signal <= 1'b0;
            ip_signal1      <= 1'b0;
            ip_signal2      <= 1'b0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_id      <= '0;
            bus.rsp_bit     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        lat_id          <= gidx;
                        last_grant      <= gidx;
                        ip_data_bus     <= sel_data;
                        ip_valid_signal <= 1'b1;
                        ip_signal1      <= sel_sig[0];
                        ip_signal2      <= sel_sig[1];
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    ip_data_bus     <= '0;
                    ip_valid_signal <= 1'b0;
                    ip_signal1      <= 1'b0;
                    ip_signal2      <= 1'b0;
                    state           <= CAPTURE;
                end
                CAPTURE: begin
                    bus.rsp_bit   <= ip_broken_output;
                    bus.rsp_id    <= lat_id;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    ip_data_bus     <= '0;
                    ip_valid_signal <= 1'b0;
                    ip_signal1      <= 1'b0;
                    ip_signal2      <= 1'b0;
                    bus.rsp_valid   <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end

endmodule
